// File: rtl/divisor_secuencial.sv
// Restoring divider: one quotient bit per clock with inicio/ocupado/listo handshake.
// Turns a battery-adder sum into quotient and remainder, e.g. an average charge.
module divisor_secuencial #(
  parameter int N_DIVIDENDO = 9,
  parameter int N_DIVISOR   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [N_DIVIDENDO-1:0] dividendo,
  input  logic [N_DIVISOR-1:0]   divisor,
  output logic [N_DIVIDENDO-1:0] cociente,
  output logic [N_DIVISOR-1:0]   residuo,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   div_cero
);

  localparam int CW = $clog2(N_DIVIDENDO + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [N_DIVIDENDO-1:0] dvd_r;
  logic [N_DIVIDENDO-1:0] quo_r;
  logic [N_DIVISOR-1:0]   dsr_r;
  logic [N_DIVISOR:0]     rem_r;
  logic [CW-1:0]          cnt;

  logic [N_DIVISOR:0]     shifted;
  logic [N_DIVISOR+1:0]   trial;
  logic                   no_borrow;
  logic [N_DIVISOR:0]     rem_next;
  logic [N_DIVIDENDO-1:0] quo_next;

  // The extra remainder bit keeps the shifted value exact for divisors >= 2^(N_DIVISOR-1);
  // the carry out of remainder + ~divisor + 1 is the "no borrow" flag.
  always_comb begin
    shifted   = {rem_r[N_DIVISOR-1:0], dvd_r[N_DIVIDENDO-1]};
    trial     = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_r}} + {{(N_DIVISOR+1){1'b0}}, 1'b1};
    no_borrow = trial[N_DIVISOR+1];
    rem_next  = no_borrow ? trial[N_DIVISOR:0] : shifted;
    quo_next  = {quo_r[N_DIVIDENDO-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dvd_r    <= '0;
      quo_r    <= '0;
      dsr_r    <= '0;
      rem_r    <= '0;
      cnt      <= '0;
      cociente <= '0;
      residuo  <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      div_cero <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (inicio) begin
            dvd_r    <= dividendo;
            dsr_r    <= divisor;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt      <= CW'(N_DIVIDENDO);
            div_cero <= 1'b0;
            if (divisor == '0) begin
              div_cero <= 1'b1;
              cociente <= '1;
              residuo  <= '0;
              listo    <= 1'b1;
              state    <= DONE;
            end else begin
              ocupado <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          dvd_r <= dvd_r << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            cociente <= quo_next;
            residuo  <= rem_next[N_DIVISOR-1:0];
            ocupado  <= 1'b0;
            listo    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Sequential restoring divider, the inverse operation of the battery adder. It consumes a 9-bit battery sum and produces quotient and remainder for a given divisor, e.g. the average charge from the sum of 2 or 4 batteries.
- Iterative: one quotient bit per clock, with a start/busy/done handshake.
- Sits downstream of the adder and feeds the display/decision logic.

Parameters:
- N_DIVIDENDO, 9: dividend and quotient width.
- N_DIVISOR, 8: divisor and remainder width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inicio  input  1  start request; sampled only in IDLE.
- dividendo  input  N_DIVIDENDO  dividend, captured when inicio is accepted.
- divisor  input  N_DIVISOR  divisor, captured when inicio is accepted.
- cociente  output  N_DIVIDENDO  quotient; valid from listo onward.
- residuo  output  N_DIVISOR  remainder; valid from listo onward.
- ocupado  output  1  high while iterating.
- listo  output  1  one-cycle pulse when results become valid.
- div_cero  output  1  set when the accepted divisor was 0.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous, active-high (rst).
- Reset: state=IDLE; cociente=0, residuo=0, ocupado=0, listo=0, div_cero=0; internal counter and working registers cleared.
- Reset mid-operation: the current division is abandoned with no listo pulse; outputs take their reset values on that edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with inicio=1, latch dividendo and divisor into internal registers.
  - Clear the partial remainder (N_DIVISOR+1 bits) and div_cero; load the iteration counter with N_DIVIDENDO.
  - If the latched divisor==0: set div_cero=1, cociente=all ones, residuo=0, go to DONE.
  - Otherwise go to CALC.
  - With inicio=0, stay in IDLE and hold the outputs.
- CALC (ocupado=1), one iteration per clock:
  - Shift the partial remainder left, inserting the next dividend bit, MSB first.
  - Trial-subtract the divisor as remainder + ~divisor + 1 (width N_DIVISOR+1).
  - If there is no borrow: keep the difference and shift 1 into the quotient. Otherwise keep the shifted remainder and shift 0 into the quotient.
  - Decrement the counter. On the edge performing the last iteration, load cociente and residuo (low N_DIVISOR bits of the partial remainder) and go to DONE.
- DONE: listo=1, ocupado=0 for exactly one cycle; next state IDLE.
- Latency: the accepting edge is E0. listo is high in the cycle after edge E0+N_DIVIDENDO, i.e. 9 clocks with the defaults. For a zero divisor, listo is high in the cycle after E0 (1 clock).
- ocupado is high for exactly N_DIVIDENDO cycles per non-zero division.
- Handshake:
  - inicio while in CALC or DONE is ignored; no queuing.
  - inicio held high continuously starts a new division on each return to IDLE, i.e. every N_DIVIDENDO+2 cycles.
  - Operand changes after acceptance have no effect on the running division.
- Hold: cociente, residuo and div_cero hold their values until the next accepted inicio updates them or rst clears them. On acceptance of a non-zero divisor, div_cero clears at the accepting edge.
- Arithmetic: unsigned only.
  - The invariant dividendo = cociente*divisor + residuo with residuo < divisor holds for every non-zero divisor.
  - The partial remainder needs N_DIVISOR+1 bits to avoid overflow when the divisor is greater than or equal to 2^(N_DIVISOR-1).

Test Plan:
- rst=1 for 2 cycles, then inicio with dividendo=300, divisor=7 → ocupado high for 9 cycles; listo pulses 1 cycle; cociente=42, residuo=6, div_cero=0.
- dividendo=510, divisor=4 (average of 4 batteries) → cociente=127, residuo=2. Then dividendo=511, divisor=1 → cociente=511, residuo=0. Then dividendo=5, divisor=9 → cociente=0, residuo=5.
- dividendo=400, divisor=255, then dividendo=511, divisor=128 (exercises the wide-divisor remainder) → 1/145, then 3/127.
- divisor=0, dividendo=77 → listo in the cycle after acceptance; div_cero=1, cociente=511, residuo=0, ocupado never high. A following 100/10 → cociente=10, residuo=0, div_cero cleared.
- Start 300/7, pulse inicio with 9/3 during CALC → ignored; results are 42/6 and there is exactly one listo pulse.
- Start 300/7, assert rst at the 4th CALC cycle → all outputs 0, no listo pulse. Release rst, start 100/3 → cociente=33, residuo=1.
